// File: rtl/load_store_unit.sv
// Load/store unit between the single-cycle datapath and a variable-latency word memory.
// Handles byte enables, store-lane replication, load extraction/extension and core stalls.
module load_store_unit #(
  parameter int n       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memread,
  input  logic         memwrite,
  input  logic [1:0]   size,
  input  logic         ld_unsigned,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] wdata,
  output logic [n-1:0] rdata,
  output logic         stall,
  output logic         misalign,
  output logic         buserr,
  output logic         mem_req,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [3:0]   mem_be,
  output logic [n-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [n-1:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    size_q;
  logic [1:0]    lane_q;
  logic          uns_q;

  logic          req;
  logic          aligned;
  logic [3:0]    be_d;
  logic [n-1:0]  wdata_d;
  logic [n-1:0]  shifted;
  logic [n-1:0]  ld_val;

  always_comb begin
    req     = memread | memwrite;
    aligned = 1'b1;
    be_d    = 4'b1111;
    wdata_d = wdata;
    case (size)
      2'b00: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      2'b01: begin
        aligned = ~addr[0];
        be_d    = 4'b0011 << addr[1:0];
        wdata_d = {2{wdata[15:0]}};
      end
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  // Lane select uses the latched offset; word accesses always have offset 0.
  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   ld_val = uns_q ? {{(n-8){1'b0}}, shifted[7:0]}
                              : {{(n-8){shifted[7]}}, shifted[7:0]};
      2'b01:   ld_val = uns_q ? {{(n-16){1'b0}}, shifted[15:0]}
                              : {{(n-16){shifted[15]}}, shifted[15:0]};
      default: ld_val = shifted;
    endcase
  end

  // Combinational so the core freezes in the very cycle the request appears.
  assign stall    = reset & ((state == ACCESS) | ((state == IDLE) & req & aligned));
  assign misalign = reset & (state == IDLE) & req & ~aligned;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      size_q    <= '0;
      lane_q    <= '0;
      uns_q     <= 1'b0;
      rdata     <= '0;
      buserr    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      buserr <= 1'b0;
      case (state)
        IDLE: begin
          if (req && aligned) begin
            mem_req   <= 1'b1;
            mem_we    <= memwrite;
            mem_addr  <= {addr[n-1:2], 2'b00};
            mem_be    <= be_d;
            mem_wdata <= wdata_d;
            size_q    <= size;
            lane_q    <= addr[1:0];
            uns_q     <= ld_unsigned;
            cnt       <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (!mem_we) rdata <= ld_val;
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            if (!mem_we) rdata <= '0;
            mem_req <= 1'b0;
            buserr  <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: a byte-addressed reference memory
// predicts each transaction; a monitor checks bus requests and completions as they appear.
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, memread, memwrite, ld_unsigned;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        stall, misalign, buserr;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  load_store_unit #(.n(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .size(size), .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .misalign(misalign), .buserr(buserr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          mis;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          berr;
    int          reqc;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  ref_mem[1024];
  logic [31:0] smem[256];
  logic [31:0] model_rdata;
  int          ack_delay = 0;
  bit          late_ack  = 1'b0;
  bit          mon_off   = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event, expected none at %0t", nm, $time);
  endtask

  // Memory slave: acks after ack_delay ACCESS cycles (never if negative); optional stray ack.
  int rcnt = 0;
  bit prq  = 1'b0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (ack_delay >= 0 && rcnt == ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            for (int k = 0; k < 4; k++)
              if (mem_be[k]) smem[mem_addr[9:2]][8*k +: 8] = mem_wdata[8*k +: 8];
          end else begin
            mem_rdata = smem[mem_addr[9:2]];
          end
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
        rcnt++;
      end else begin
        rcnt = 0;
        if (late_ack && prq) begin
          mem_ack   = 1'b1;
          mem_rdata = $urandom;
          late_ack  = 1'b0;
        end else begin
          mem_ack = 1'b0;
        end
      end
      prq = mem_req;
    end
  end

  // Monitor: request launch, completion and misalign events against the scoreboard.
  bit   ps = 1'b0, pr = 1'b0;
  int   sc = 0, rc = 0;
  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset || mon_off) begin
        ps = 1'b0; pr = 1'b0; sc = 0; rc = 0;
      end else begin
        if (stall)   sc++;
        if (mem_req) rc++;
        if (misalign) begin
          if (q.size() == 0) flag("unexpected_misalign");
          else begin
            me = q.pop_front();
            chk("mis_expected", 32'(misalign), 32'(me.mis));
            chk("mis_rdata", rdata, me.rdata);
            chk("mis_stall", 32'(stall), 32'd0);
            chk("mis_req", 32'(mem_req), 32'd0);
          end
          sc = 0; rc = 0;
        end else if (mem_req && !pr) begin
          if (q.size() == 0) flag("unexpected_req");
          else begin
            me = q[0];
            chk("req_not_misaligned", 32'(me.mis), 32'd0);
            chk("req_we", 32'(mem_we), 32'(me.we));
            chk("req_addr", mem_addr, me.addr);
            chk("req_be", 32'(mem_be), 32'(me.be));
            chk("req_wdata", mem_wdata, me.wdata);
            chk("req_buserr", 32'(buserr), 32'd0);
          end
        end else if (!stall && ps) begin
          if (q.size() == 0) flag("unexpected_done");
          else begin
            me = q.pop_front();
            chk("done_rdata", rdata, me.rdata);
            chk("done_buserr", 32'(buserr), 32'(me.berr));
            chk("done_req_cycles", 32'(rc), 32'(me.reqc));
            chk("done_stall_cycles", 32'(sc), 32'(me.reqc + 1));
          end
          sc = 0; rc = 0;
        end
        ps = stall;
        pr = mem_req;
      end
    end
  end

  // Issue one instruction at posedge+1; returns at posedge+1 after it retires.
  task automatic issue(input bit wr, input bit rd, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd, input int dly);
    exp_t        e;
    int          nb, k;
    bit          al;
    logic [31:0] v;
    nb      = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    al      = (int'(a[1:0]) % nb) == 0;
    e.mis   = !al;
    e.we    = wr;
    e.addr  = {a[31:2], 2'b00};
    e.be    = '0;
    for (int i = 0; i < nb; i++) e.be[(int'(a[1:0]) + i) % 4] = 1'b1;
    e.wdata = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
    e.berr  = 1'b0;
    e.reqc  = 0;
    if (al) begin
      if (dly < 0) begin
        e.reqc = TO;
        e.berr = 1'b1;
        if (!wr) model_rdata = '0;
      end else begin
        e.reqc = dly + 1;
        if (wr) begin
          for (int i = 0; i < nb; i++) ref_mem[int'(a[9:0]) + i] = wd[8*i +: 8];
        end else begin
          v = '0;
          for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[int'(a[9:0]) + i];
          if (nb < 4 && !uns && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
          model_rdata = v;
        end
      end
    end
    e.rdata = model_rdata;
    q.push_back(e);
    ack_delay   = dly;
    memwrite    = wr;
    memread     = rd;
    size        = sz;
    ld_unsigned = uns;
    addr        = a;
    wdata       = wd;
    @(negedge clk);
    if (al) begin
      k = 0;
      while (stall && k < 40) begin
        @(negedge clk);
        k++;
      end
      if (k >= 40) flag("stall_bound_expired");
    end
    @(posedge clk);
    #1;
    memread  = 1'b0;
    memwrite = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit          rwr, rrd, runs;
  logic [1:0]  rsz;
  logic [31:0] ra, rwd;
  int          rnb, rdly;

  initial begin
    reset = 1'b0; memread = 1'b1; memwrite = 1'b0; size = 2'b10;
    ld_unsigned = 1'b0; addr = '0; wdata = '0; model_rdata = '0;
    for (int w = 0; w < 256; w++) begin
      smem[w] = $urandom;
      for (int i = 0; i < 4; i++) ref_mem[4*w + i] = smem[w][8*i +: 8];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, '0);
    chk("rst_stall", 32'(stall), '0);
    chk("rst_misalign", 32'(misalign), '0);
    chk("rst_buserr", 32'(buserr), '0);
    chk("rst_req", 32'(mem_req), '0);
    chk("rst_we", 32'(mem_we), '0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_be", 32'(mem_be), '0);
    chk("rst_wdata", mem_wdata, '0);
    memread = 1'b0;
    reset   = 1'b1;
    mon_off = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    issue(1, 0, 2'b10, 0, 32'h100, 32'hDEADBEEF, 0);
    issue(1, 0, 2'b10, 0, 32'h200, 32'h80FF1234, 1);
    issue(0, 1, 2'b00, 0, 32'h203, 32'h0, 3);
    chk("byte_signed_const", rdata, 32'hFFFFFF80);
    issue(0, 1, 2'b00, 1, 32'h203, 32'h0, 3);
    chk("byte_unsigned_const", rdata, 32'h00000080);
    issue(1, 0, 2'b01, 0, 32'h42, 32'h0000ABCD, 2);
    issue(0, 1, 2'b10, 0, 32'h101, 32'h0, 0);
    chk("misalign_rdata_kept", rdata, 32'h00000080);
    issue(1, 1, 2'b10, 0, 32'h104, 32'h12345678, 0);

    late_ack = 1'b1;
    issue(0, 1, 2'b10, 0, 32'h100, 32'h0, -1);
    repeat (2) @(posedge clk);
    #1;
    chk("late_ack_rdata", rdata, '0);
    chk("late_ack_req", 32'(mem_req), '0);
    chk("late_ack_stall", 32'(stall), '0);

    mon_off = 1'b1; ack_delay = -1;
    memread = 1'b1; size = 2'b10; addr = 32'h300; ld_unsigned = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_req_before", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("rstmid_req", 32'(mem_req), '0);
    chk("rstmid_stall", 32'(stall), '0);
    chk("rstmid_rdata", rdata, '0);
    chk("rstmid_be", 32'(mem_be), '0);
    late_ack = 1'b1;
    memread  = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_stall", 32'(stall), '0);
    chk("post_rst_req", 32'(mem_req), '0);
    chk("post_rst_rdata", rdata, '0);
    model_rdata = '0;
    mon_off = 1'b0;
    issue(0, 1, 2'b10, 0, 32'h100, 32'h0, 1);
    chk("post_rst_load", rdata, 32'hDEADBEEF);

    for (int t = 0; t < 150; t++) begin
      int r;
      r    = $urandom % 10;
      rwr  = (r < 4) || (r == 9);
      rrd  = (r >= 4);
      rsz  = 2'($urandom % 4);
      runs = 1'($urandom % 2);
      rnb  = (rsz == 2'b00) ? 1 : (rsz == 2'b01) ? 2 : 4;
      ra   = $urandom % 1024;
      if ($urandom % 5 != 0) ra = ra & 32'(~(rnb - 1));
      rwd  = $urandom;
      rdly = ($urandom % 20 == 0) ? -1 : int'($urandom % 4);
      issue(rwr, rrd, rsz, runs, ra, rwd, rdly);
      if ($urandom % 2 == 1) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
